// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: default Q2.6 geometry, divider FSM states,
// saturation limits.
package fixed_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_FRAC  = 6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
endpackage

// File: rtl/fixed_sat.sv
// Sign + unsigned wide magnitude -> saturated signed W-bit value and overflow flag.
// Also intended for requantising the multiply path.
module fixed_sat #(
  parameter int W     = 8,
  parameter int MAG_W = 14
) (
  input  logic             sign,
  input  logic [MAG_W-1:0] mag,
  output logic [W-1:0]     res,
  output logic             ovf
);
  localparam logic [MAG_W-1:0] POS_LIM = {{(MAG_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [MAG_W-1:0] NEG_LIM = POS_LIM + MAG_W'(1);
  localparam logic [W-1:0]     S_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     S_MIN   = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    res = '0;
    ovf = 1'b0;
    if (sign) begin
      // -2^(W-1) itself is representable, so the negative limit is one larger
      if (mag > NEG_LIM) begin
        res = S_MIN;
        ovf = 1'b1;
      end else begin
        res = W'(~mag[W-1:0]) + W'(1);
      end
    end else if (mag > POS_LIM) begin
      res = S_MAX;
      ovf = 1'b1;
    end else begin
      res = mag[W-1:0];
    end
  end
endmodule

// File: rtl/fixed_div_seq.sv
// Sequential signed Q(W-F).F restoring divider, one quotient bit per cycle.
// FIXED_DIV_ROUND_EN: compute one extra bit and round half away from zero.
module fixed_div_seq
  import fixed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic             div_by_zero,
  output logic             overflow
);
`ifdef FIXED_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int NI = WIDTH + FRAC + RND;
  localparam int CW = $clog2(NI);
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  rem, rem_nx, dvs, a_mag, b_mag;
  logic [WIDTH:0]    rem_sh;
  logic [NI-1:0]     dq, dq_nx, q_mag;
  logic              sgn, q_bit, b_zero;
  logic [WIDTH-1:0]  sat_q;
  logic              sat_ovf;

  assign a_mag  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign b_zero = (b == '0);

  // dq starts as the shifted dividend; quotient bits fill in from the LSB
  assign rem_sh = {rem, dq[NI-1]};
  assign q_bit  = (rem_sh >= {1'b0, dvs});
  assign rem_nx = q_bit ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
  assign dq_nx  = {dq[NI-2:0], q_bit};

`ifdef FIXED_DIV_ROUND_EN
  assign q_mag = NI'(dq_nx[NI-1:1]) + NI'(dq_nx[0]);
`else
  assign q_mag = dq_nx;
`endif

  fixed_sat #(.W(WIDTH), .MAG_W(NI)) u_sat (
    .sign (sgn),
    .mag  (q_mag),
    .res  (sat_q),
    .ovf  (sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = b_zero ? DONE : CALC;
      CALC:    if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      rem         <= '0;
      dq          <= '0;
      dvs         <= '0;
      sgn         <= 1'b0;
      quot        <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn <= a[WIDTH-1] ^ b[WIDTH-1];
          dq  <= {a_mag, {(NI-WIDTH){1'b0}}};
          dvs <= b_mag;
          rem <= '0;
          cnt <= CW'(NI-1);
          if (b_zero) begin
            quot        <= a[WIDTH-1] ? S_MIN : S_MAX;
            div_by_zero <= 1'b1;
            overflow    <= 1'b1;
          end
        end
        CALC: begin
          rem <= rem_nx;
          dq  <= dq_nx;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            quot        <= sat_q;
            div_by_zero <= 1'b0;
            overflow    <= sat_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
endmodule

// File: tb/tb_fixed_div_seq.sv
// Randomised + directed bench for fixed_div_seq against an arithmetic model.
// Expectations follow FIXED_DIV_ROUND_EN when it is defined.
module tb_fixed_div_seq;
  import fixed_pkg::*;
  localparam int W = DEF_WIDTH;
  localparam int F = DEF_FRAC;
`ifdef FIXED_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, div_by_zero, overflow;
  logic [W-1:0] quot;

  fixed_div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Real-valued quotient a/b scaled by 2^F, truncated or rounded, then clipped
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output int q, output int dz, output int ov);
    int A, B, num, den, m, r;
    A = $signed(av);
    B = $signed(bv);
    dz = 0; ov = 0;
    if (B == 0) begin
      dz = 1; ov = 1;
      q = (A < 0) ? 'h80 : 'h7F;
      return;
    end
    num = (A < 0 ? -A : A) * (1 << F);
    den = (B < 0 ? -B : B);
    if (RND == 1) m = (2 * num + den) / (2 * den);
    else          m = num / den;
    r = ((A < 0) != (B < 0)) ? -m : m;
    if (r > 127)       begin r = 127;  ov = 1; end
    else if (r < -128) begin r = -128; ov = 1; end
    q = r & 'hFF;
  endfunction

  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int qe, input int dze, input int ove, input int stall);
    int lat;
    @(negedge clk);
    chk({nm, ".in_ready"}, int'(in_ready), 1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    chk({nm, ".lat"}, lat, (dze != 0) ? 1 : 1 + W + F + RND);
    chk({nm, ".quot"}, int'(quot), qe);
    chk({nm, ".dbz"}, int'(div_by_zero), dze);
    chk({nm, ".ovf"}, int'(overflow), ove);
    chk({nm, ".busy"}, int'(in_ready), 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk({nm, ".hold_q"}, int'(quot), qe);
      chk({nm, ".hold_f"}, int'({overflow, div_by_zero}), (ove << 1) | dze);
      chk({nm, ".hold_v"}, int'({out_valid, in_ready}), 2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, ".release"}, int'({out_valid, in_ready}), 1);
  endtask

  logic [W-1:0] da [9] = '{8'h20, 8'h40, 8'hC0, 8'h02, 8'hFE, 8'h40, 8'h80, 8'h80, 8'h00};
  logic [W-1:0] db [9] = '{8'h40, 8'h20, 8'h20, 8'h03, 8'h03, 8'h00, 8'h00, 8'h40, 8'hFF};
`ifdef FIXED_DIV_ROUND_EN
  int dq [9] = '{'h20, 'h7F, 'h80, 'h2B, 'hD5, 'h7F, 'h80, 'h80, 'h00};
`else
  int dq [9] = '{'h20, 'h7F, 'h80, 'h2A, 'hD6, 'h7F, 'h80, 'h80, 'h00};
`endif
  int dd [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
  int dv [9] = '{0, 1, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    int q, dz, ov;
    logic [W-1:0] ra, rb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.quot", int'(quot), 0);
    chk("rst.flags", int'({overflow, div_by_zero}), 0);
    chk("rst.in_ready", int'(in_ready), 1);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("dir%0d", i), da[i], db[i], dq[i], dd[i], dv[i], 0);

    // long DONE stall
    run_op("stall", 8'h20, 8'h40, 'h20, 0, 0, 5);

    // reset in the middle of CALC
    @(negedge clk);
    a = 8'h40; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst.out_valid", int'(out_valid), 0);
    chk("mid_rst.quot", int'(quot), 0);
    chk("mid_rst.flags", int'({overflow, div_by_zero}), 0);
    chk("mid_rst.in_ready", int'(in_ready), 1);
    @(negedge clk); rst = 1'b1;
    run_op("post_rst", 8'h02, 8'h03, dq[3], 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(ra, rb, q, dz, ov);
      run_op($sformatf("rnd%0d_%02h_%02h", i, ra, rb), ra, rb, q, dz, ov,
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
